// File: rtl/alu2_seq_pkg.sv
// Shared types and widths for the wide ALU byte sequencer.
package alu2_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_e;

  localparam int BYTE_W = 8;
  localparam int OPC_W  = 3;

endpackage

// File: rtl/alu2_wide_sequencer.sv
// Splits one BYTES-wide command into LSB-first byte ops on a carry4_alu2, chaining carry.
// Optional ALU2_SEQ_TIMEOUT_EN bounds each WAIT and reports rsp_error on expiry.
module alu2_wide_sequencer
  import alu2_seq_pkg::*;
#(
  parameter int BYTES          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPC_W-1:0]        cmd_opcode,
  input  logic                    cmd_carryin,
  input  logic [BYTE_W*BYTES-1:0] cmd_operand0,
  input  logic [BYTE_W*BYTES-1:0] cmd_operand1,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [BYTE_W*BYTES-1:0] rsp_result,
  output logic                    rsp_carryflag,
  output logic                    rsp_zeroflag,
  output logic                    rsp_signflag,
  output logic                    rsp_error,
  output logic                    alu_enable,
  output logic                    alu_write,
  output logic                    alu_strobe,
  output logic                    alu_carryflag,
  output logic [OPC_W-1:0]        alu_opcode,
  output logic [BYTE_W-1:0]       alu_operand0,
  output logic [BYTE_W-1:0]       alu_operand1,
  input  logic [BYTE_W-1:0]       alu_result,
  input  logic                    alu_carry_o,
  input  logic                    alu_zero_o,
  input  logic                    alu_sign_o,
  input  logic                    alu_ready
);

  localparam int W  = BYTE_W * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  seq_state_e     state_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   op0_q, op1_q, res_q;
  logic           zacc_q;

  logic [W-1:0]   res_d;
  logic [IW-1:0]  idx_d;
  logic           last;
  logic           tmo_hit;

  always_comb begin
    res_d = res_q;
    res_d[BYTE_W*idx_q +: BYTE_W] = alu_result;
    idx_d = idx_q + IW'(1);
    last  = (idx_q == IW'(BYTES-1));
  end

`ifdef ALU2_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (state_q == WAIT) && !alu_ready && (tmo_q + TW'(1) == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmo_q     <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (state_q == ISSUE)     tmo_q <= '0;
      else if (state_q == WAIT) tmo_q <= tmo_q + TW'(1);
      if (tmo_hit)                           rsp_error <= 1'b1;
      else if (state_q == RESP && rsp_ready) rsp_error <= 1'b0;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign rsp_error = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      op0_q         <= '0;
      op1_q         <= '0;
      res_q         <= '0;
      zacc_q        <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_carryflag <= 1'b0;
      rsp_zeroflag  <= 1'b0;
      rsp_signflag  <= 1'b0;
      alu_enable    <= 1'b0;
      alu_write     <= 1'b0;
      alu_strobe    <= 1'b0;
      alu_carryflag <= 1'b0;
      alu_opcode    <= '0;
      alu_operand0  <= '0;
      alu_operand1  <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          // Byte 0 is presented straight from the command so ISSUE starts next cycle.
          op0_q         <= cmd_operand0;
          op1_q         <= cmd_operand1;
          res_q         <= '0;
          idx_q         <= '0;
          zacc_q        <= 1'b1;
          cmd_ready     <= 1'b0;
          alu_enable    <= 1'b1;
          alu_write     <= 1'b1;
          alu_strobe    <= 1'b1;
          alu_carryflag <= cmd_carryin;
          alu_opcode    <= cmd_opcode;
          alu_operand0  <= cmd_operand0[BYTE_W-1:0];
          alu_operand1  <= cmd_operand1[BYTE_W-1:0];
          state_q       <= ISSUE;
        end
        ISSUE: begin
          alu_write  <= 1'b0;
          alu_strobe <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: if (alu_ready) begin
          res_q         <= res_d;
          zacc_q        <= zacc_q & alu_zero_o;
          alu_carryflag <= alu_carry_o;
          if (last) begin
            alu_enable    <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_result    <= res_d;
            rsp_carryflag <= alu_carry_o;
            rsp_zeroflag  <= zacc_q & alu_zero_o;
            rsp_signflag  <= alu_sign_o;
            state_q       <= RESP;
          end else begin
            idx_q        <= idx_d;
            alu_write    <= 1'b1;
            alu_strobe   <= 1'b1;
            alu_operand0 <= op0_q[BYTE_W*idx_d +: BYTE_W];
            alu_operand1 <= op1_q[BYTE_W*idx_d +: BYTE_W];
            state_q      <= ISSUE;
          end
        end else if (tmo_hit) begin
          alu_enable    <= 1'b0;
          rsp_valid     <= 1'b1;
          rsp_result    <= '0;
          rsp_carryflag <= 1'b0;
          rsp_zeroflag  <= 1'b0;
          rsp_signflag  <= 1'b0;
          state_q       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu2_wide_sequencer.sv
// Directed scoreboard bench for alu2_wide_sequencer against a 2-cycle add-with-carry ALU model.
module tb_alu2_wide_sequencer;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;
  localparam int TMO   = 40;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c, z, s, e;
  } exp_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_carryin = 1'b0;
  logic [2:0]   cmd_opcode = '0;
  logic [W-1:0] cmd_operand0 = '0, cmd_operand1 = '0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_carryflag, rsp_zeroflag, rsp_signflag, rsp_error;
  logic         alu_enable, alu_write, alu_strobe, alu_carryflag;
  logic [2:0]   alu_opcode;
  logic [7:0]   alu_operand0, alu_operand1, alu_result;
  logic         alu_carry_o, alu_zero_o, alu_sign_o, alu_ready;

  int   checks = 0, errors = 0;
  int   strobe_total = 0, strobe_base = 0;
  bit   never_ready = 1'b0;
  exp_t sb[$];

  always #5 aclk = ~aclk;

  alu2_wide_sequencer #(.BYTES(BYTES), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_carryin(cmd_carryin), .cmd_operand0(cmd_operand0), .cmd_operand1(cmd_operand1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carryflag(rsp_carryflag), .rsp_zeroflag(rsp_zeroflag), .rsp_signflag(rsp_signflag),
    .rsp_error(rsp_error),
    .alu_enable(alu_enable), .alu_write(alu_write), .alu_strobe(alu_strobe),
    .alu_carryflag(alu_carryflag), .alu_opcode(alu_opcode),
    .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
    .alu_result(alu_result), .alu_carry_o(alu_carry_o), .alu_zero_o(alu_zero_o),
    .alu_sign_o(alu_sign_o), .alu_ready(alu_ready)
  );

  // ALU model: add with carry, result latched on strobe, ready pulses 2 cycles later.
  logic [8:0] alu_sum;
  logic [1:0] alu_cnt;
  assign alu_sum = {1'b0, alu_operand0} + {1'b0, alu_operand1} + {8'd0, alu_carryflag};

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      alu_cnt <= '0; alu_ready <= 1'b0; alu_result <= '0;
      alu_carry_o <= 1'b0; alu_zero_o <= 1'b0; alu_sign_o <= 1'b0;
    end else begin
      alu_ready <= 1'b0;
      if (alu_strobe) begin
        alu_result  <= alu_sum[7:0];
        alu_carry_o <= alu_sum[8];
        alu_zero_o  <= (alu_sum[7:0] == 8'd0);
        alu_sign_o  <= alu_sum[7];
        alu_cnt     <= never_ready ? 2'd0 : 2'd2;
      end else if (alu_cnt != 2'd0) begin
        alu_cnt <= alu_cnt - 2'd1;
        if (alu_cnt == 2'd1) alu_ready <= 1'b1;
      end
    end
  end

  always @(posedge aclk) if (alu_strobe) strobe_total <= strobe_total + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit exp_err);
    bit ok = 1'b0;
    logic [W:0] sum;
    exp_t e;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      ok = cmd_ready;
    end
    chk("cmd_ready_wait", W'(ok), W'(1));
    cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_carryin = cin;
    cmd_operand0 = a; cmd_operand1 = b;
    strobe_base = strobe_total;
    @(posedge aclk); #1;
    // Scramble the command bus: the sequencer must work from its latched copy.
    cmd_valid = 1'b0; cmd_carryin = ~cin;
    cmd_operand0 = $urandom; cmd_operand1 = $urandom;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.r = exp_err ? '0 : sum[W-1:0];
    e.c = sum[W];
    e.z = (sum[W-1:0] == '0);
    e.s = sum[W-1];
    e.e = exp_err;
    sb.push_back(e);
  endtask

  task automatic recv(input int hold);
    bit got = 1'b0;
    exp_t e;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge aclk);
      got = rsp_valid;
    end
    chk("rsp_valid_wait", W'(got), W'(1));
    chk("sb_depth", W'(sb.size()), W'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", rsp_result, e.r);
      chk("error", W'(rsp_error), W'(e.e));
      if (!e.e) begin
        chk("carry", W'(rsp_carryflag), W'(e.c));
        chk("zero", W'(rsp_zeroflag), W'(e.z));
        chk("sign", W'(rsp_signflag), W'(e.s));
      end
      chk("strobes", W'(strobe_total - strobe_base), e.e ? W'(1) : W'(BYTES));
      chk("enable_low_in_resp", W'(alu_enable), W'(0));
      for (int i = 0; i < hold; i++) begin
        @(negedge aclk);
        chk("hold_valid", W'(rsp_valid), W'(1));
        chk("hold_result", rsp_result, e.r);
        chk("hold_cmd_ready", W'(cmd_ready), W'(0));
      end
    end
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_after_rsp", W'(cmd_ready), W'(1));
    chk("valid_dropped", W'(rsp_valid), W'(0));
  endtask

  initial begin
    bit hit = 1'b0;
    #12;
    chk("rst_cmd_ready", W'(cmd_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_alu_enable", W'(alu_enable), W'(0));
    chk("rst_alu_strobe", W'(alu_strobe), W'(0));
    chk("rst_alu_operand0", W'(alu_operand0), W'(0));
    @(negedge aclk); aresetn = 1'b1;

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); recv(0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); recv(0);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); recv(0);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0); recv(10);

    // Abort during the WAIT of byte 2: reset clears outputs immediately, no response.
    send(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge aclk);
      hit = (strobe_total - strobe_base == 3) && !alu_strobe;
    end
    chk("reach_byte2_wait", W'(hit), W'(1));
    aresetn = 1'b0; #1;
    chk("abort_cmd_ready", W'(cmd_ready), W'(1));
    chk("abort_alu_enable", W'(alu_enable), W'(0));
    chk("abort_alu_operand1", W'(alu_operand1), W'(0));
    chk("abort_alu_carry", W'(alu_carryflag), W'(0));
    chk("abort_rsp_valid", W'(rsp_valid), W'(0));
    void'(sb.pop_back());
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    send(32'h0001_0000, 32'hFFFF_0000, 1'b1, 1'b0); recv(0);

    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); recv(0);
    for (int k = 0; k < 4; k++) begin
      send($urandom, $urandom, 1'($urandom_range(1)), 1'b0);
      recv(k);
    end

`ifdef ALU2_SEQ_TIMEOUT_EN
    never_ready = 1'b1;
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b1); recv(0);
    never_ready = 1'b0;
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0); recv(0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
